// File: rtl/mem_map_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_map_pkg
//  Description : Shared 12-bit memory map (region encoding and bounds) for the
//                address decoder, the CPU read mux and the MMR block.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_map_pkg;

   localparam int              ADDR_W    = 12;
   localparam logic [11:0]     INSTR_END = 12'h400;
   localparam logic [11:0]     MMR_END   = 12'h44B;

   typedef enum logic [1:0] {
      instructions = 2'd0,
      mmr          = 2'd1,
      stack        = 2'd2
   } region_t;

endpackage
`default_nettype wire

// File: rtl/mem_region_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mem_region_decode
//  Description : Pure combinational address-to-region classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_region_decode
   import mem_map_pkg::*;
#(
   parameter int                ADDR_W    = mem_map_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] INSTR_END = mem_map_pkg::INSTR_END,
   parameter logic [ADDR_W-1:0] MMR_END   = mem_map_pkg::MMR_END
) (
   input  logic [ADDR_W-1:0] addr,
   output region_t           region
);

   // Bounds are inclusive; anything above MMR_END falls into the stack.
   always_comb begin
      region = instructions;
      if (addr <= INSTR_END) begin
         region = instructions;
      end else if (addr <= MMR_END) begin
         region = mmr;
      end else begin
         region = stack;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_addr_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_addr_decoder
//  Description : Read-mux select and region-qualified write enables for the
//                CPU data bus, plus a registered region/write-error snapshot.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_addr_decoder
   import mem_map_pkg::*;
#(
   parameter int                ADDR_W    = mem_map_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] INSTR_END = mem_map_pkg::INSTR_END,
   parameter logic [ADDR_W-1:0] MMR_END   = mem_map_pkg::MMR_END
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              MEMLOAD,
   output logic [1:0]        sel,
   output logic              load_mmr,
   output logic              load_stack,
   output logic [1:0]        region_q,
   output logic              wr_err_q
);

   region_t state;
   region_t r_region_q;
   logic    r_wr_err_q;

   mem_region_decode #(
      .ADDR_W    (ADDR_W),
      .INSTR_END (INSTR_END),
      .MMR_END   (MMR_END)
   ) u_region_decode (
      .addr   (addr),
      .region (state)
   );

   // Instruction memory is never writable through this path, so only the
   // MMR and stack regions get an enable.
   assign sel        = state;
   assign load_mmr   = MEMLOAD & (state == mmr);
   assign load_stack = MEMLOAD & (state == stack);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_region_q <= instructions;
         r_wr_err_q <= 1'b0;
      end else begin
         r_region_q <= state;
         r_wr_err_q <= r_wr_err_q | (MEMLOAD & (state == instructions));
      end
   end

   assign region_q = r_region_q;
   assign wr_err_q = r_wr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_addr_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_addr_decoder
//  Description : Self-checking bench for mem_addr_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_addr_decoder;

   logic        clk;
   logic        rst;
   logic [11:0] addr;
   logic        MEMLOAD;
   logic [1:0]  sel;
   logic        load_mmr;
   logic        load_stack;
   logic [1:0]  region_q;
   logic        wr_err_q;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [1:0] sel;
      logic       lm;
      logic       ls;
   } comb_exp_t;

   typedef struct {
      logic [1:0] rq;
      logic       err;
   } reg_exp_t;

   comb_exp_t comb_q[$];
   reg_exp_t  reg_q[$];
   logic      m_err = 1'b0;

   mem_addr_decoder dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .MEMLOAD    (MEMLOAD),
      .sel        (sel),
      .load_mmr   (load_mmr),
      .load_stack (load_stack),
      .region_q   (region_q),
      .wr_err_q   (wr_err_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] ref_region(input logic [11:0] a);
      if (a < 12'h401)      return 2'd0;
      else if (a < 12'h44C) return 2'd1;
      else                  return 2'd2;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t addr=%03h)", tag, obs, exp, $time, addr);
      end
   endtask

   // Registered-output scoreboard: expectation pushed at the edge, compared half a cycle later.
   always @(posedge clk) begin
      reg_exp_t e;
      if (rst) begin
         m_err = 1'b0;
         e.rq  = 2'd0;
      end else begin
         m_err = m_err | (MEMLOAD & (ref_region(addr) == 2'd0));
         e.rq  = ref_region(addr);
      end
      e.err = m_err;
      reg_q.push_back(e);
   end

   always @(negedge clk) begin
      reg_exp_t e;
      if (reg_q.size() == 0) begin
         check("reg_queue_empty", 32'd1, 32'd0);
      end else begin
         e = reg_q.pop_front();
         check("sb_region_q", region_q, e.rq);
         check("sb_wr_err_q", wr_err_q, e.err);
      end
   end

   task automatic apply(input logic r, input logic [11:0] a, input logic m);
      comb_exp_t e;
      @(negedge clk);
      rst     = r;
      addr    = a;
      MEMLOAD = m;
      e.sel = ref_region(a);
      e.lm  = m & (e.sel == 2'd1);
      e.ls  = m & (e.sel == 2'd2);
      comb_q.push_back(e);
      #1;
      e = comb_q.pop_front();
      check("sel", sel, e.sel);
      check("state", dut.state, e.sel);
      check("load_mmr", load_mmr, e.lm);
      check("load_stack", load_stack, e.ls);
      check("enables_exclusive", load_mmr & load_stack, 1'b0);
   endtask

   task automatic after_edge;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst     = 1'b1;
      addr    = 12'h000;
      MEMLOAD = 1'b0;
      after_edge();
      check("reset_region_q", region_q, 2'd0);
      check("reset_wr_err_q", wr_err_q, 1'b0);

      // Full sweep with writes enabled
      for (int a = 0; a <= 12'hFFE; a++) begin
         apply(1'b0, a[11:0], 1'b1);
      end

      // Boundaries with writes disabled
      apply(1'b0, 12'h400, 1'b0);
      check("b400_sel", sel, 2'd0);
      apply(1'b0, 12'h401, 1'b0);
      check("b401_sel", sel, 2'd1);
      apply(1'b0, 12'h44B, 1'b0);
      check("b44B_sel", sel, 2'd1);
      apply(1'b0, 12'h44C, 1'b0);
      check("b44C_sel", sel, 2'd2);
      apply(1'b0, 12'hFFF, 1'b0);
      check("bFFF_sel", sel, 2'd2);
      check("bFFF_no_write", {load_mmr, load_stack}, 2'b00);

      // Reset, then a stack write
      apply(1'b1, 12'h44C, 1'b1);
      after_edge();
      check("rst_region_q", region_q, 2'd0);
      check("rst_wr_err_q", wr_err_q, 1'b0);
      apply(1'b0, 12'h44C, 1'b1);
      after_edge();
      check("stack_region_q", region_q, 2'd2);
      check("stack_wr_err_q", wr_err_q, 1'b0);

      // Write attempt to the instruction region sets the sticky flag
      apply(1'b0, 12'h010, 1'b1);
      check("instr_no_enable", {load_mmr, load_stack}, 2'b00);
      after_edge();
      check("err_set", wr_err_q, 1'b1);
      apply(1'b0, 12'h500, 1'b0);
      after_edge();
      check("err_sticky", wr_err_q, 1'b1);
      check("err_sticky_region_q", region_q, 2'd2);

      // Reset held: combinational outputs still decode, registers stay cleared
      for (int a = 12'h3FF; a <= 12'h402; a++) begin
         apply(1'b1, a[11:0], 1'b1);
         after_edge();
         check("hold_rst_region_q", region_q, 2'd0);
         check("hold_rst_wr_err_q", wr_err_q, 1'b0);
      end

      // Randomised traffic with occasional reset
      for (int i = 0; i < 10000; i++) begin
         apply(($urandom_range(0, 63) == 0), 12'($urandom()), 1'($urandom()));
         check("sel_not_3", (sel == 2'd3), 1'b0);
      end

      @(negedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
